// File: rtl/instr_mem_loadable.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_loadable
// Description : Loadable instruction memory for the IF stage. A program is
//               written through the load port while in LOAD mode. In RUN
//               mode, fetches return the word at the PC through a registered
//               read with one cycle of latency. A stall input freezes the
//               fetch outputs. Unloaded, out-of-range or misaligned fetches
//               return HALT_WORD.
// Ports       : clk, rst                - clock, async active-high reset
//               ld_mode                 - 1 = LOAD requested, 0 = RUN requested
//               ld_we/ld_addr/ld_data   - load write port (byte address)
//               ld_count                - distinct words written since reset
//               if_req/if_stall         - fetch request, downstream stall
//               if_from_pc              - fetch byte address
//               if_instruction          - fetched word (registered)
//               if_valid/if_misalign    - fresh result flag, PC bit-0 flag
// Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_loadable #(
  parameter int               DATA_W    = 16,
  parameter int               ADDR_W    = 16,
  parameter int               DEPTH     = 32,
  parameter logic [DATA_W-1:0] HALT_WORD = 16'h0000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ld_mode,
  input  logic                      ld_we,
  input  logic [ADDR_W-1:0]         ld_addr,
  input  logic [DATA_W-1:0]         ld_data,
  output logic [$clog2(DEPTH):0]    ld_count,
  input  logic                      if_req,
  input  logic                      if_stall,
  input  logic [ADDR_W-1:0]         if_from_pc,
  output logic [DATA_W-1:0]         if_instruction,
  output logic                      if_valid,
  output logic                      if_misalign
);

  localparam int c_IDX_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_IDX_W + 1;
  // Byte-address limit held one bit wider than the address so that the
  // DEPTH*2 == 2**ADDR_W corner still compares correctly.
  localparam logic [ADDR_W:0]    c_LIMIT  = (ADDR_W+1)'(2 * DEPTH);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [DEPTH-1:0]   r_loaded;
  logic [c_CNT_W-1:0] r_ld_count;
  logic [DATA_W-1:0]  r_instr;
  logic               r_valid;
  logic               r_misalign;

  logic [c_IDX_W-1:0] w_ld_idx;
  logic [c_IDX_W-1:0] w_if_idx;
  logic               w_ld_in_range;
  logic               w_if_in_range;
  logic               w_ld_ok;
  logic               w_ld_new;

  // --------------------------------------------------------------------------
  // Mode state machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  w_state_next = ld_mode ? S_LOAD : S_RUN;
      S_LOAD:  if (!ld_mode) w_state_next = S_RUN;
      S_RUN:   if (ld_mode)  w_state_next = S_LOAD;
      default: w_state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Address decode. Range checks use the full address width so that upper
  // PC bits never alias onto a valid index.
  // --------------------------------------------------------------------------
  always_comb begin
    w_ld_idx      = ld_addr[c_IDX_W:1];
    w_if_idx      = if_from_pc[c_IDX_W:1];
    w_ld_in_range = ({1'b0, ld_addr} < c_LIMIT);
    w_if_in_range = ({1'b0, if_from_pc} < c_LIMIT);
    w_ld_ok       = (r_state == S_LOAD) && ld_we && !ld_addr[0] && w_ld_in_range;
    w_ld_new      = w_ld_ok && !r_loaded[w_ld_idx];
  end

  // --------------------------------------------------------------------------
  // Storage array: no reset, so contents survive rst; validity is tracked
  // separately in r_loaded.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_ld_ok) begin
      r_mem[w_ld_idx] <= ld_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_loaded   <= '0;
      r_ld_count <= '0;
    end else begin
      if (w_ld_ok) begin
        r_loaded[w_ld_idx] <= 1'b1;
      end
      // Only first-time writes count; rewrites leave the counter alone.
      if (w_ld_new && (r_ld_count != c_CNT_MAX)) begin
        r_ld_count <= r_ld_count + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Fetch path
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr    <= HALT_WORD;
      r_valid    <= 1'b0;
      r_misalign <= 1'b0;
    end else if (r_state != S_RUN) begin
      r_valid <= 1'b0;
    end else if (ld_mode) begin
      // Leaving RUN drops the valid flag even under stall.
      r_valid <= 1'b0;
    end else if (!if_stall) begin
      if (if_req) begin
        r_valid <= 1'b1;
        if (if_from_pc[0]) begin
          r_instr    <= HALT_WORD;
          r_misalign <= 1'b1;
        end else if (!w_if_in_range || !r_loaded[w_if_idx]) begin
          r_instr    <= HALT_WORD;
          r_misalign <= 1'b0;
        end else begin
          r_instr    <= r_mem[w_if_idx];
          r_misalign <= 1'b0;
        end
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign ld_count       = r_ld_count;
  assign if_instruction = r_instr;
  assign if_valid       = r_valid;
  assign if_misalign    = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loadable.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_mem_loadable
// Description : Directed self-checking bench for instr_mem_loadable
//               (DATA_W=16, ADDR_W=16, DEPTH=32, HALT_WORD=0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_mem_loadable;

  logic        clk;
  logic        rst;
  logic        ld_mode;
  logic        ld_we;
  logic [15:0] ld_addr;
  logic [15:0] ld_data;
  logic [5:0]  ld_count;
  logic        if_req;
  logic        if_stall;
  logic [15:0] if_from_pc;
  logic [15:0] if_instruction;
  logic        if_valid;
  logic        if_misalign;

  int checks;
  int failures;

  instr_mem_loadable #(
    .DATA_W   (16),
    .ADDR_W   (16),
    .DEPTH    (32),
    .HALT_WORD(16'h0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ld_mode       (ld_mode),
    .ld_we         (ld_we),
    .ld_addr       (ld_addr),
    .ld_data       (ld_data),
    .ld_count      (ld_count),
    .if_req        (if_req),
    .if_stall      (if_stall),
    .if_from_pc    (if_from_pc),
    .if_instruction(if_instruction),
    .if_valid      (if_valid),
    .if_misalign   (if_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_fetch(input string tag, input logic [15:0] instr,
                           input logic valid, input logic mis);
    chk({tag, ".instr"}, 32'(if_instruction), 32'(instr));
    chk({tag, ".valid"}, 32'(if_valid), 32'(valid));
    chk({tag, ".mis"},   32'(if_misalign), 32'(mis));
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    ld_mode    = 1'b0;
    ld_we      = 1'b0;
    ld_addr    = '0;
    ld_data    = '0;
    if_req     = 1'b0;
    if_stall   = 1'b0;
    if_from_pc = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_fetch("reset", 16'h0000, 1'b0, 1'b0);
    chk("reset.count", 32'(ld_count), 32'd0);
    rst = 1'b0;

    // 1. Load two words, switch to RUN, fetch 0x0002
    ld_mode = 1'b1;
    tick();                                   // IDLE -> LOAD
    ld_we = 1'b1; ld_addr = 16'h0000; ld_data = 16'hFE21;
    tick();
    ld_addr = 16'h0002; ld_data = 16'hFB22;
    tick();
    chk("t1.count_load", 32'(ld_count), 32'd2);
    ld_we = 1'b0; ld_mode = 1'b0;
    tick();                                   // LOAD -> RUN
    chk("t1.valid_idle", 32'(if_valid), 32'd0);
    if_req = 1'b1; if_from_pc = 16'h0002;
    tick();
    chk_fetch("t1.fetch2", 16'hFB22, 1'b1, 1'b0);
    chk("t1.count", 32'(ld_count), 32'd2);

    // 2. Unloaded and out-of-range fetches, including would-be aliases of 0
    if_from_pc = 16'h0004;
    tick();
    chk_fetch("t2.unloaded", 16'h0000, 1'b1, 1'b0);
    if_from_pc = 16'h0040;
    tick();
    chk_fetch("t2.oor40", 16'h0000, 1'b1, 1'b0);
    if_from_pc = 16'h8000;
    tick();
    chk_fetch("t2.oor8000", 16'h0000, 1'b1, 1'b0);

    // 3. Misaligned fetch, idle request, dropped loads
    if_from_pc = 16'h0003;
    tick();
    chk_fetch("t3.misalign", 16'h0000, 1'b1, 1'b1);
    if_req = 1'b0;
    tick();
    chk_fetch("t3.noreq", 16'h0000, 1'b0, 1'b1);
    ld_mode = 1'b1;
    tick();                                   // RUN -> LOAD
    ld_we = 1'b1; ld_addr = 16'h0003; ld_data = 16'h1234;
    tick();
    chk("t3.count_misalign_wr", 32'(ld_count), 32'd2);
    ld_addr = 16'h0040; ld_data = 16'h5555;
    tick();
    chk("t3.count_oor_wr", 32'(ld_count), 32'd2);
    ld_we = 1'b0; ld_mode = 1'b0;
    tick();                                   // LOAD -> RUN
    if_req = 1'b1; if_from_pc = 16'h0002;
    tick();
    chk_fetch("t3.word1_intact", 16'hFB22, 1'b1, 1'b0);
    if_from_pc = 16'h0000;
    tick();
    chk_fetch("t3.word0_intact", 16'hFE21, 1'b1, 1'b0);

    // 4. Stall holds outputs for three cycles, release fetches new PC
    if_stall = 1'b1; if_from_pc = 16'h0002;
    tick();
    chk_fetch("t4.stall1", 16'hFE21, 1'b1, 1'b0);
    tick();
    chk_fetch("t4.stall2", 16'hFE21, 1'b1, 1'b0);
    tick();
    chk_fetch("t4.stall3", 16'hFE21, 1'b1, 1'b0);
    if_stall = 1'b0;
    tick();
    chk_fetch("t4.release", 16'hFB22, 1'b1, 1'b0);

    // 5. Rewrites do not count; ld_we in RUN is ignored
    if_req = 1'b0; ld_mode = 1'b1;
    tick();                                   // RUN -> LOAD
    chk("t5.leave_valid", 32'(if_valid), 32'd0);
    ld_we = 1'b1; ld_addr = 16'h0000; ld_data = 16'h2388;
    tick();
    tick();
    chk("t5.count_rewrite", 32'(ld_count), 32'd2);
    ld_we = 1'b0; ld_mode = 1'b0;
    tick();                                   // LOAD -> RUN
    if_req = 1'b1; if_from_pc = 16'h0000;
    tick();
    chk_fetch("t5.rewritten", 16'h2388, 1'b1, 1'b0);
    ld_we = 1'b1; ld_addr = 16'h0000; ld_data = 16'hBEEF;
    tick();
    ld_addr = 16'h0004; ld_data = 16'h4444;
    tick();
    ld_we = 1'b0;
    chk_fetch("t5.run_we_ignored", 16'h2388, 1'b1, 1'b0);
    chk("t5.run_we_count", 32'(ld_count), 32'd2);
    if_from_pc = 16'h0004;
    tick();
    chk_fetch("t5.run_we_unloaded", 16'h0000, 1'b1, 1'b0);
    if_from_pc = 16'h0000;
    tick();
    chk_fetch("t5.refetch", 16'h2388, 1'b1, 1'b0);

    // Leaving RUN while stalled still drops valid, holds instruction
    if_stall = 1'b1; ld_mode = 1'b1;
    tick();                                   // RUN -> LOAD
    chk_fetch("t5.leave_stalled", 16'h2388, 1'b0, 1'b0);
    if_stall = 1'b0; if_req = 1'b0;

    // 6a. Reset mid-LOAD
    ld_we = 1'b1; ld_addr = 16'h0004; ld_data = 16'h7777;
    tick();
    chk("t6.count_new", 32'(ld_count), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk_fetch("t6.rst_load", 16'h0000, 1'b0, 1'b0);
    chk("t6.rst_load_count", 32'(ld_count), 32'd0);
    rst = 1'b0; ld_we = 1'b0; ld_mode = 1'b0;
    tick();                                   // IDLE -> RUN
    if_req = 1'b1; if_from_pc = 16'h0000;
    tick();
    chk_fetch("t6.after_rst_fetch", 16'h0000, 1'b1, 1'b0);

    // 6b. Reset mid-stall
    if_req = 1'b0; ld_mode = 1'b1;
    tick();                                   // RUN -> LOAD
    ld_we = 1'b1; ld_addr = 16'h0000; ld_data = 16'hABCD;
    tick();
    chk("t6.reload_count", 32'(ld_count), 32'd1);
    ld_we = 1'b0; ld_mode = 1'b0;
    tick();                                   // LOAD -> RUN
    if_req = 1'b1;
    tick();
    chk_fetch("t6.reload_fetch", 16'hABCD, 1'b1, 1'b0);
    if_stall = 1'b1; if_from_pc = 16'h0003;
    tick();
    chk_fetch("t6.stall_hold", 16'hABCD, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_fetch("t6.rst_stall", 16'h0000, 1'b0, 1'b0);
    chk("t6.rst_stall_count", 32'(ld_count), 32'd0);
    rst = 1'b0; if_stall = 1'b0; if_req = 1'b0;
    tick();                                   // IDLE -> RUN
    if_req = 1'b1; if_from_pc = 16'h0000;
    tick();
    chk_fetch("t6.final_fetch", 16'h0000, 1'b1, 1'b0);
    chk("t6.final_count", 32'(ld_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
